// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the datapath (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_m;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data memory: byte/half/word loads and stores with a fixed
// number of wait states, fault detection and a stall to the hazard unit.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic        load_ok_reg;
  logic [31:0] rd_word_reg;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;
  logic        c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_off;
  logic [AW-1:0] c_idx;
  logic [3:0]  c_be;
  logic [31:0] c_wlanes;
  logic        c_err;
  logic [3:0]  lane_we;

  assign accept = (state_reg == IDLE) && bus.req_valid;

  // With zero wait states the acceptance edge is also the commit edge, so the
  // access is taken straight from the request rather than the latched copy.
  assign commit   = rst && ((LATENCY == 0) ? accept
                                           : (state_reg == BUSY && cnt_reg == 4'd0));
  assign c_we     = (LATENCY == 0) ? bus.req_we     : we_reg;
  assign c_funct3 = (LATENCY == 0) ? bus.req_funct3 : funct3_reg;
  assign c_addr   = (LATENCY == 0) ? bus.req_addr   : addr_reg;
  assign c_wdata  = (LATENCY == 0) ? bus.req_wdata  : wdata_reg;
  assign c_off    = c_addr[1:0];
  assign c_idx    = c_addr[AW+1:2];

  always_comb begin
    c_be     = 4'b1111;
    c_wlanes = c_wdata;
    case (c_funct3[1:0])
      2'b00: begin
        c_be     = 4'b0001 << c_off;
        c_wlanes = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        c_be     = c_off[1] ? 4'b1100 : 4'b0011;
        c_wlanes = {2{c_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    c_err = 1'b0;
    case (c_funct3)
      3'b000:  c_err = 1'b0;
      3'b001:  c_err = c_off[0];
      3'b010:  c_err = |c_off;
      3'b100:  c_err = c_we;
      3'b101:  c_err = c_we | c_off[0];
      default: c_err = 1'b1;
    endcase
    if ({2'b00, c_addr[31:2]} >= 32'(DEPTH))
      c_err = 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = commit & c_we & ~c_err & c_be[gi];
  end

  // RAM is left unreset so it maps onto block memory; read-first at commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (lane_we[i])
          mem[c_idx][8*i +: 8] <= c_wlanes[8*i +: 8];
      rd_word_reg <= mem[c_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      load_ok_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= commit;
      rsp_err_reg   <= commit & c_err;
      load_ok_reg   <= commit & ~c_we & ~c_err;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg     <= bus.req_we;
            funct3_reg <= bus.req_funct3;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            if (LATENCY == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == 4'd0) state_reg <= RESP;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_ext;

  assign byte_sel = rd_word_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

  always_comb begin
    rdata_ext = 32'd0;
    case (funct3_reg)
      3'b000:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_ext = rd_word_reg;
      3'b100:  rdata_ext = {24'd0, byte_sel};
      3'b101:  rdata_ext = {16'd0, half_sel};
      default: rdata_ext = 32'd0;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.stall_m   = accept | (state_reg == BUSY);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = load_ok_reg ? rdata_ext : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with none, checked against a byte-addressed reference memory.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();

  logic        drv_valid [2];
  logic        drv_we    [2];
  logic [2:0]  drv_f3    [2];
  logic [31:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic        mon_ready [2];
  logic        mon_valid [2];
  logic        mon_err   [2];
  logic        mon_stall [2];
  logic [31:0] mon_rdata [2];

  assign if_a.req_valid  = drv_valid[0];
  assign if_a.req_we     = drv_we[0];
  assign if_a.req_funct3 = drv_f3[0];
  assign if_a.req_addr   = drv_addr[0];
  assign if_a.req_wdata  = drv_wdata[0];
  assign if_b.req_valid  = drv_valid[1];
  assign if_b.req_we     = drv_we[1];
  assign if_b.req_funct3 = drv_f3[1];
  assign if_b.req_addr   = drv_addr[1];
  assign if_b.req_wdata  = drv_wdata[1];

  assign mon_ready[0] = if_a.req_ready;
  assign mon_valid[0] = if_a.rsp_valid;
  assign mon_err[0]   = if_a.rsp_err;
  assign mon_stall[0] = if_a.stall_m;
  assign mon_rdata[0] = if_a.rsp_rdata;
  assign mon_ready[1] = if_b.req_ready;
  assign mon_valid[1] = if_b.rsp_valid;
  assign mon_err[1]   = if_b.rsp_err;
  assign mon_stall[1] = if_b.stall_m;
  assign mon_rdata[1] = if_b.rsp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic [7:0] mdl [2][4*DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: byte-granular memory, access legality from the RV32I rules.
  task automatic model(input int s, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, output logic [31:0] rd, output logic err);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (f3[2] && we) ||
           (addr % size != 0) || (addr / 4 >= DEPTH);
    rd   = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mdl[s][addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[s][addr + i];
        if (!f3[2] && size < 4 && v[8*size - 1])
          for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
        rd = v;
      end
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int L = (gi == 0) ? LAT_A : LAT_B;
    exp_t q[$];
    int   stall_cnt = 0;
    int   rsp_count = 0;
    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        stall_cnt = 0;
      end else begin
        if (mon_stall[gi]) stall_cnt++;
        if (mon_valid[gi]) begin
          rsp_count++;
          if (q.size() == 0) begin
            check($sformatf("unexpected_rsp%0d", gi), 32'(q.size()), 32'd1);
          end else begin
            e = q.pop_front();
            $display("[TB] dut%0d rsp rdata=%h err=%0b", gi, mon_rdata[gi], mon_err[gi]);
            check($sformatf("rdata%0d", gi), mon_rdata[gi], e.rdata);
            check($sformatf("err%0d", gi), 32'(mon_err[gi]), 32'(e.err));
            check($sformatf("latency%0d", gi), 32'(cyc - e.acc), 32'(L + 1));
            check($sformatf("stall_cycles%0d", gi), 32'(stall_cnt), 32'(L + 1));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic push_exp(input int s, input exp_t e);
    if (s == 0) g_mon[0].q.push_back(e);
    else        g_mon[1].q.push_back(e);
  endtask

  // Called at posedge+1; returns one step after the acceptance edge.
  task automatic issue(input int s, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit hold, input bit expect_rsp);
    int guard = 0;
    exp_t e;
    while (!mon_ready[s] && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'(mon_ready[s]), 32'd1);
    drv_valid[s] = 1'b1;
    drv_we[s]    = we;
    drv_f3[s]    = f3;
    drv_addr[s]  = addr;
    drv_wdata[s] = wdata;
    $display("[TB] dut%0d req we=%0b f3=%0d addr=%h wdata=%h", s, we, f3, addr, wdata);
    if (expect_rsp) begin
      model(s, we, f3, addr, wdata, e.rdata, e.err);
      e.acc = cyc;
      push_exp(s, e);
    end
    @(posedge clk); #1;
    check("ready_low_after_accept", 32'(mon_ready[s]), 32'd0);
    if (!hold) drv_valid[s] = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 32'(g_mon[0].q.size() + g_mon[1].q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    bit [31:0] a;
    int s;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0; drv_we[i] = 1'b0; drv_f3[i] = 3'd0;
      drv_addr[i]  = 32'd0; drv_wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(mon_ready[i]), 32'd1);
      check("reset_rsp_valid", 32'(mon_valid[i]), 32'd0);
      check("reset_rsp_err", 32'(mon_err[i]), 32'd0);
      check("reset_rdata", mon_rdata[i], 32'd0);
      check("reset_stall", 32'(mon_stall[i]), 32'd0);
    end

    issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1);
    issue(0, 0, 3'b010, 32'h10, 32'h0, 0, 1);
    issue(0, 1, 3'b010, 32'h10, 32'h0, 0, 1);
    issue(0, 1, 3'b000, 32'h13, 32'h80, 0, 1);
    issue(0, 0, 3'b000, 32'h13, 32'h0, 0, 1);
    issue(0, 0, 3'b100, 32'h13, 32'h0, 0, 1);
    issue(0, 0, 3'b010, 32'h10, 32'h0, 0, 1);
    issue(0, 1, 3'b010, 32'h20, 32'h0, 0, 1);
    issue(0, 1, 3'b001, 32'h22, 32'h8001, 0, 1);
    issue(0, 0, 3'b001, 32'h22, 32'h0, 0, 1);
    issue(0, 0, 3'b101, 32'h22, 32'h0, 0, 1);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 0, 1);
    issue(0, 0, 3'b010, 32'h11, 32'h0, 0, 1);
    issue(0, 0, 3'b010, 32'h10, 32'h0, 0, 1);
    issue(0, 1, 3'b001, 32'h23, 32'hFFFF, 0, 1);
    issue(0, 0, 3'b010, 32'h20, 32'h0, 0, 1);
    issue(0, 0, 3'b010, 32'(4*DEPTH), 32'h0, 0, 1);
    issue(0, 1, 3'b010, 32'h30, 32'h12345678, 0, 1);
    wait_drain();

    // Abandon a store in BUSY with an asynchronous reset.
    issue(0, 1, 3'b010, 32'h30, 32'hCAFEF00D, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(mon_valid[0]), 32'd0);
    check("midrst_rsp_err", 32'(mon_err[0]), 32'd0);
    check("midrst_rdata", mon_rdata[0], 32'd0);
    check("midrst_ready", 32'(mon_ready[0]), 32'd1);
    check("midrst_stall", 32'(mon_stall[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 3'b010, 32'h30, 32'h0, 0, 1);
    wait_drain();

    for (int si = 0; si < 2; si++)
      for (int w = 0; w < 16; w++)
        issue(si, 1, 3'b010, 32'(4*w), $urandom, 0, 1);
    wait_drain();

    // Four loads with req_valid held high on each instance.
    for (int si = 0; si < 2; si++) begin
      c0 = (si == 0) ? g_mon[0].rsp_count : g_mon[1].rsp_count;
      for (int k = 0; k < 4; k++)
        issue(si, 0, 3'b010, 32'(4*$urandom_range(0, 15)), 32'h0, (k < 3), 1);
      wait_drain();
      check("b2b_pulses", 32'(((si == 0) ? g_mon[0].rsp_count : g_mon[1].rsp_count) - c0), 32'd4);
    end

    for (int n = 0; n < 120; n++) begin
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 63));
      issue(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0, 1);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave answering the datapath's memory-stage load/store requests (address = ALU result, store data = forwarded rs2).
- Multi-cycle, word-organised RAM with RV32I byte, halfword and word access.
- Sign/zero-extends loads; flags misaligned or out-of-range accesses.
- Drives a stall to the hazard unit until the access completes.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 2, wait-state cycles between acceptance and response; range 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage access present
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (RV32I encoding)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  responder can accept a request this cycle
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access fault, valid with rsp_valid
- stall_m  out  1  hold fetch/decode/execute/memory stages

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- req_ready = (state==IDLE).
- stall_m = (IDLE & req_valid) | BUSY. It is low in RESP so the pipeline advances and captures rsp_rdata.
- Acceptance: at the edge where IDLE & req_valid, latch we, funct3, addr and wdata.
  - LATENCY>0: go to BUSY with cnt=LATENCY-1.
  - LATENCY=0: go straight to RESP.
- BUSY: cnt decrements each cycle; at cnt==0 go to RESP. req_valid is ignored outside IDLE.
- Commit edge (entering RESP):
  - Stores update only the addressed byte lanes.
  - Loads register the extended data into rsp_rdata.
- RESP: lasts exactly one cycle with rsp_valid=1, then return to IDLE.
- Timing: rsp_valid is high LATENCY+1 cycles after the acceptance edge. Back-to-back throughput is one access per LATENCY+2 cycles.
- Word index = addr[log2(DEPTH)+1:2]. Byte offset = addr[1:0]. Little-endian.
- Store lanes:
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all lanes.
- Load extension:
  - lb/lh sign-extend bit 7/15 of the selected field.
  - lbu/lhu zero-extend.
  - lw returns the word.
- Error (rsp_err=1, no write, rsp_rdata=0) on any of:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - funct3 in {011,110,111}
  - funct3 in {100,101} with req_we=1
  - addr[31:2] >= DEPTH
- Errored accesses still take the full latency.
- Reset (asynchronous, rst=0):
  - state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 after release; stall_m follows req_valid.
  - RAM contents are not reset (undefined until written).
- Reset mid-operation: an access in BUSY is abandoned, with no write and no response. A store whose commit edge coincides with reset assertion is not guaranteed.
- Read-after-write: a load accepted after a store's RESP cycle returns the new data. No other ordering exists because there is one outstanding access.

Test Plan:
- LATENCY=2: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rsp_valid 3 cycles after each acceptance; rdata 0xDEADBEEF; stall_m high for 3 cycles per access.
- sb 0x13 data 0x80 over word 0x00000000 -> lb 0x13 returns 0xFFFFFF80; lbu returns 0x00000080; lw 0x10 returns 0x80000000.
- sh 0x22 data 0x8001 -> lh 0x22 returns 0xFFFF8001; lhu returns 0x00008001; lw 0x20 returns 0x80010000.
- lw 0x11, sh 0x23, and lw 4*DEPTH -> rsp_err=1, rdata 0, following lw of the target word unchanged.
- Hold req_valid high for 4 consecutive loads -> exactly 4 rsp_valid pulses; req_ready low during BUSY/RESP. Repeat with LATENCY=0: pulse every 2 cycles.
- Assert rst during BUSY of sw 0x30 -> outputs zero immediately, no rsp_valid, lw 0x30 returns the prior contents.
